// File: rtl/scan_pkg.sv
// Shared constants and small helpers for the multiplexed seven-segment scanner.
package scan_pkg;

  localparam int         NDIG      = 6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_IDLE   = 8'hFF;

  typedef logic [2:0] dig_idx_t;

  // Active-low anode pattern for one digit; bits [7:6] never go low.
  function automatic logic [7:0] an_onecold(input dig_idx_t idx);
    logic [7:0] an;
    case (idx)
      3'd0:    an = 8'hFE;
      3'd1:    an = 8'hFD;
      3'd2:    an = 8'hFB;
      3'd3:    an = 8'hF7;
      3'd4:    an = 8'hEF;
      3'd5:    an = 8'hDF;
      default: an = AN_IDLE;
    endcase
    return an;
  endfunction

  // Pick the segment byte belonging to one digit out of the packed input.
  function automatic logic [7:0] sel_byte(input logic [47:0] segs, input dig_idx_t idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = segs[7:0];
      3'd1:    b = segs[15:8];
      3'd2:    b = segs[23:16];
      3'd3:    b = segs[31:24];
      3'd4:    b = segs[39:32];
      3'd5:    b = segs[47:40];
      default: b = SEG_BLANK;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/scan_blink_timer.sv
// Blink timer: counts completed scan frames and toggles the blink phase
// every BLINK_HALF frames. Only built when SCAN_CTRL_BLINK_EN is defined.
module scan_blink_timer
  import scan_pkg::*;
#(
  parameter int BLINK_HALF = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_phase
);

  localparam logic [9:0] FC_LAST = 10'(BLINK_HALF - 1);

  logic [9:0] fc_q, fc_d;
  logic       phase_q, phase_d;

  assign o_phase = phase_q;

  // Next frame count and phase; a clear (scan disabled) restarts both.
  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    if (i_clr) begin
      fc_d    = 10'd0;
      phase_d = 1'b0;
    end else if (i_tick) begin
      if (fc_q == FC_LAST) begin
        fc_d    = 10'd0;
        phase_d = ~phase_q;
      end else begin
        fc_d    = fc_q + 10'd1;
      end
    end else begin
      fc_d    = fc_q;
    end
  end

  // Frame counter and phase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q    <= 10'd0;
      phase_q <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Six-digit multiplexed display scanner with PWM brightness.
// Optional digit blinking is compiled in with macro SCAN_CTRL_BLINK_EN.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL      = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [47:0] i_seg,
  input  logic [5:0]  i_blink_mask,
  input  logic [2:0]  i_bright,
  output logic [7:0]  o_an,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam logic [12:0] CNT_LAST = 13'(DWELL - 1);
  localparam logic [16:0] DWELL_W  = 17'(DWELL);
  localparam dig_idx_t    IDX_LAST = 3'(NDIG - 1);

  logic [12:0] cnt_q, cnt_d;
  dig_idx_t    idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        frame_q, frame_d;

  logic [16:0] thr_s;
  logic        lit_s;
  logic        last_cnt_s;
  logic        wrap_s;
  logic        blink_dark_s;
  logic [7:0]  cur_seg_s;

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_frame = frame_q;

  assign last_cnt_s = (cnt_q == CNT_LAST);
  assign wrap_s     = last_cnt_s && (idx_q == IDX_LAST);

`ifdef SCAN_CTRL_BLINK_EN
  logic       phase_s;
  logic       tick_s;
  logic [7:0] mask8_s;

  assign tick_s  = wrap_s & i_enable;
  assign mask8_s = {2'b00, i_blink_mask};

  scan_blink_timer #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (!i_enable),
    .i_tick  (tick_s),
    .o_phase (phase_s)
  );

  assign blink_dark_s = phase_s & mask8_s[idx_q];
`else
  logic unused_blink_s;
  assign unused_blink_s = ^{i_blink_mask, 10'(BLINK_HALF)};
  assign blink_dark_s   = 1'b0;
`endif

  // Brightness window: the digit is lit for the first (bright+1)/8 of its dwell.
  always_comb begin
    thr_s = ((({14'd0, i_bright}) + 17'd1) * DWELL_W) >> 3;
    lit_s = ({4'd0, cnt_q} < thr_s) && !blink_dark_s;
  end

  // Scan sequencing, segment capture and next output values.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    an_d      = AN_IDLE;
    seg_d     = SEG_BLANK;
    frame_d   = 1'b0;
    cur_seg_s = hold_q;
    if (!i_enable) begin
      cnt_d = 13'd0;
      idx_d = 3'd0;
    end else begin
      // The byte sampled at cnt==0 is shown right away, so it bypasses hold_q.
      if (cnt_q == 13'd0) begin
        cur_seg_s = sel_byte(i_seg, idx_q);
        hold_d    = cur_seg_s;
      end else begin
        cur_seg_s = hold_q;
      end
      if (last_cnt_s) begin
        cnt_d = 13'd0;
        if (idx_q == IDX_LAST) begin
          idx_d = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 13'd1;
      end
      frame_d = wrap_s;
      if (lit_s) begin
        an_d  = an_onecold(idx_q);
        seg_d = cur_seg_s;
      end else begin
        an_d  = AN_IDLE;
        seg_d = SEG_BLANK;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 13'd0;
      idx_q   <= 3'd0;
      hold_q  <= SEG_BLANK;
      an_q    <= AN_IDLE;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl with DWELL=16, BLINK_HALF=2.
module tb_scan_ctrl;

  localparam int DW    = 16;
  localparam int BH    = 2;
  localparam int FRAME = 6 * DW;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [47:0] i_seg;
  logic [5:0]  i_blink_mask;
  logic [2:0]  i_bright;
  logic [7:0]  o_an;
  logic [7:0]  o_seg;
  logic        o_frame;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [2:0]  bright;
    logic [47:0] seg;
    logic [5:0]  mask;
    int          lit;
    int          frames;
  } vec_t;

  vec_t vecs[4];

  logic [7:0] an_tab[6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

  scan_ctrl #(.DWELL(DW), .BLINK_HALF(BH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_seg        (i_seg),
    .i_blink_mask (i_blink_mask),
    .i_bright     (i_bright),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_frame      (o_frame)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, k, act, exp);
  endtask

  task automatic check1(input string name, input int k, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %b expected %b", name, k, act, exp);
  endtask

  // Hold reset for a cycle and release on a falling edge; the scan then
  // starts from cnt=0, idx=0 at the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check8("rst_an", 0, o_an, 8'hFF);
    check8("rst_seg", 0, o_seg, 8'hFF);
    check1("rst_frame", 0, o_frame, 1'b0);
    reset = 1'b1;
  endtask

  // Run nsteps cycles from a fresh scan start. i_seg switches from seg0 to
  // seg1 just before step chg_k; lit = lit cycles per 16-cycle dwell.
  task automatic run_steps(input string name, input int nsteps, input int lit,
                           input logic [47:0] seg0, input logic [47:0] seg1,
                           input int chg_k);
    exp_t       e, got;
    logic [47:0] src;
    int          d, c, f, k0;
    logic        dark, lit_e;
    i_seg = seg0;
    for (int k = 0; k < nsteps; k++) begin
      if (k == chg_k) i_seg = seg1;
      d  = (k / DW) % 6;
      c  = k % DW;
      f  = k / FRAME;
      k0 = k - c;
      src = (k0 >= chg_k) ? seg1 : seg0;
`ifdef SCAN_CTRL_BLINK_EN
      dark = i_blink_mask[d] && (((f / BH) % 2) == 1);
`else
      dark = 1'b0;
`endif
      lit_e   = (c < lit) && !dark;
      e.an    = lit_e ? an_tab[d] : 8'hFF;
      e.seg   = lit_e ? src[8*d +: 8] : 8'hFF;
      e.frame = ((k % FRAME) == FRAME - 1);
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = sb_q.pop_front();
      check8({name, "_an"}, k, o_an, got.an);
      check8({name, "_seg"}, k, o_seg, got.seg);
      check1({name, "_frame"}, k, o_frame, got.frame);
    end
  endtask

  initial begin
    int frames_seen;

    vecs[0] = '{"order", 3'd7, 48'h0102_0304_0506, 6'b000000, 16, 2};
    vecs[1] = '{"duty1", 3'd1, 48'hA1B2_C3D4_E5F6, 6'b000000, 4,  1};
    vecs[2] = '{"duty0", 3'd0, 48'h1122_3344_5566, 6'b000000, 2,  1};
    vecs[3] = '{"blink", 3'd7, 48'h4F5E_6D7C_8B9A, 6'b000011, 16, 6};

    reset        = 1'b0;
    i_enable     = 1'b1;
    i_seg        = 48'h0;
    i_blink_mask = 6'b0;
    i_bright     = 3'd7;

    // Table-driven scans: order, duty levels, blink mask.
    for (int v = 0; v < 4; v++) begin
      i_bright     = vecs[v].bright;
      i_blink_mask = vecs[v].mask;
      do_reset();
      run_steps(vecs[v].name, vecs[v].frames * FRAME, vecs[v].lit,
                vecs[v].seg, vecs[v].seg, 1 << 30);
    end
    i_blink_mask = 6'b0;

    // Hold: digit 0 byte changes at cnt=5 and shows only on the next visit.
    i_bright = 3'd7;
    do_reset();
    run_steps("hold", FRAME + DW, 16, 48'h0102_0304_0506, 48'h0102_0304_05AA, 5);

    // Asynchronous reset mid-scan blanks immediately; digit 0 follows release.
    do_reset();
    run_steps("pre", 37, 16, 48'h0102_0304_0506, 48'h0102_0304_0506, 1 << 30);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check8("async_an", 0, o_an, 8'hFF);
    check8("async_seg", 0, o_seg, 8'hFF);
    check1("async_frame", 0, o_frame, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_steps("post", 20, 16, 48'h0102_0304_0506, 48'h0102_0304_0506, 1 << 30);

    // Enable dropped at idx=3: blank, no frame pulses; restart at digit 0.
    do_reset();
    run_steps("en_pre", 50, 16, 48'h0102_0304_0506, 48'h0102_0304_0506, 1 << 30);
    i_enable    = 1'b0;
    frames_seen = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk);
      @(negedge clk);
      check8("dis_an", k, o_an, 8'hFF);
      check8("dis_seg", k, o_seg, 8'hFF);
      if (o_frame) frames_seen++;
    end
    n_total++;
    if (frames_seen == 0) n_pass++;
    else $display("FAIL dis_frames: got %0d expected 0", frames_seen);
    i_enable = 1'b1;
    run_steps("en_post", FRAME + 4, 16, 48'h0102_0304_0506, 48'h0102_0304_0506, 1 << 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 1000: clk cycles each digit is driven; legal range 8..8191.
REQ-002 SHALL have parameter BLINK_HALF, default 250: scan frames per blink half-period; legal range 1..1023.
REQ-003 SHALL have port clk  in  1  single system clock; all state rises on posedge clk.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_enable  in  1  scan enable; low blanks the display.
REQ-006 SHALL have port i_seg  in  48  six active-low segment patterns; bits [8k+7:8k] are digit k (k=0 sec-ones ... k=5 hour-tens).
REQ-007 SHALL have port i_blink_mask  in  6  bit k set means digit k blinks.
REQ-008 SHALL have port i_bright  in  3  brightness level 0..7.
REQ-009 SHALL have port o_an  out  8  active-low digit enables; bits [7:6] are always 1.
REQ-010 SHALL have port o_seg  out  8  active-low segments; 8'hFF is blank.
REQ-011 SHALL have port o_frame  out  1  one-cycle pulse at each digit 5->0 wrap.

Function
REQ-012 SHALL keep dwell counter cnt, counting 0..DWELL-1 and returning to 0, and digit index idx, counting 0..5 and returning to 0.
REQ-013 SHALL increment idx when cnt==DWELL-1; idx 5 wraps to 0, and o_frame is 1 in the cycle after that wrap.
REQ-014 SHALL capture digit idx's i_seg byte into a hold register when cnt==0; changes to i_seg during the dwell have no effect until the next dwell.
REQ-015 SHALL light digit idx when cnt < ((i_bright+1)*DWELL)>>3, computed at >=17-bit width; otherwise it drives o_an=8'hFF and o_seg=8'hFF.
REQ-016 SHALL drive lit outputs as o_an = ~(1<<idx) and o_seg = the hold register.
REQ-017 SHALL register all outputs, giving one-cycle latency from cnt/idx state.
REQ-018 SHALL make o_an exactly one-cold or all-ones; two low bits at once is a bug.
REQ-019 SHALL, when i_enable is low, drive outputs blank on the next cycle, clear cnt, idx and the blink state, and hold o_frame at 0.
REQ-020 SHALL restart at idx=0, cnt=0 after a 0->1 transition of i_enable.
REQ-021 SHALL sample i_bright every cycle; a change mid-dwell takes effect immediately.

Reset
REQ-022 SHALL, while reset is low, asynchronously force o_an=8'hFF, o_seg=8'hFF, o_frame=0, cnt=0, idx=0, hold=8'hFF, blink phase=0, frame counter=0.
REQ-023 SHALL, after reset deasserts, output digit 0 on the first cycle following the first cnt==0 capture.
REQ-024 SHALL return every register to its REQ-022 value when reset asserts mid-dwell or mid-blink.

Configuration
REQ-025 SHALL compile the blink logic only under macro SCAN_CTRL_BLINK_EN.
REQ-026 SHALL, with SCAN_CTRL_BLINK_EN: count frames 0..BLINK_HALF-1, toggle the blink phase on the wrap, and blank masked digits while phase=1, exactly as in REQ-015.
REQ-027 SHALL, without SCAN_CTRL_BLINK_EN: leave i_blink_mask unused and synthesize no frame counter.

Structure
REQ-028 SHALL take NDIG=6, SEG_BLANK=8'hFF and AN_IDLE=8'hFF from shared package scan_pkg.
REQ-029 SHALL place the frame counter and phase toggle in the single sub-module scan_blink_timer, instantiated only under SCAN_CTRL_BLINK_EN.

Verification (DWELL=16, BLINK_HALF=2)
REQ-030 SHALL check reset: reset low mid-scan -> o_an=FF and o_seg=FF immediately; after release, digit 0 is lit.
REQ-031 SHALL check scan order: i_bright=7, i_seg=48'h0102_0304_0506 -> o_an sequence FE,FD,FB,F7,EF,DF, each held 16 cycles, with o_seg 06,05,04,03,02,01 and one o_frame pulse per 96 cycles.
REQ-032 SHALL check duty: i_bright=1 -> each digit is lit 4 of 16 cycles; i_bright=0 -> lit 2 of 16.
REQ-033 SHALL check hold: i_seg byte 0 changed at cnt=5 of digit 0 -> o_seg is unchanged until the next visit to digit 0.
REQ-034 SHALL check blink (SCAN_CTRL_BLINK_EN): i_blink_mask=6'b000011 -> digits 0-1 are dark in frames 2-3, lit in frames 0-1 and 4-5; digits 2-5 are never dark.
REQ-035 SHALL check enable: i_enable dropped at idx=3 -> outputs blank and no o_frame; on re-enable the scan restarts at FE.
